// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four packet streams.
// Grant is held per packet; a beat counter forces release at MAX_BEATS.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  input  logic [4*WIDTH-1:0] req_data,
  input  logic [3:0]         req_last,
  output logic [3:0]         req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic [1:0]         out_src,
  input  logic               out_ready
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BEATS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_n;
  logic [1:0]    grant, grant_n;
  logic [1:0]    ptr, ptr_n;
  logic [CW-1:0] beats, beats_n;
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          fire;

  assign out_src = grant;

  // Rotating-priority scan: the set bit closest to ptr wins
  always_comb begin
    pick = ptr;
    idx  = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req_valid[idx]) pick = idx;
    end
  end

  // Steer the granted requester's slice to the output
  always_comb begin
    unique case (grant)
      2'd0: out_data = req_data[0*WIDTH +: WIDTH];
      2'd1: out_data = req_data[1*WIDTH +: WIDTH];
      2'd2: out_data = req_data[2*WIDTH +: WIDTH];
      2'd3: out_data = req_data[3*WIDTH +: WIDTH];
    endcase
  end

  // Next-state and handshake outputs
  always_comb begin
    state_n   = state;
    grant_n   = grant;
    ptr_n     = ptr;
    beats_n   = beats;
    out_valid = 1'b0;
    out_last  = 1'b0;
    req_ready = '0;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          grant_n = pick;
          beats_n = '0;
          state_n = BUSY;
        end
      end
      BUSY: begin
        out_valid        = req_valid[grant];
        out_last         = req_last[grant] || (beats == LAST_BEAT);
        req_ready[grant] = out_ready;
        fire             = out_valid && out_ready;
        if (fire) begin
          if (out_last) begin
            state_n = IDLE;
            ptr_n   = grant + 2'd1;
            beats_n = '0;
          end else begin
            beats_n = beats + CW'(1);
          end
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      beats <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr   <= ptr_n;
      beats <= beats_n;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: queued requester models,
// expected beats {src,last,data} compared on every downstream handshake.
module tb_mux4_rr_arbiter;

  localparam int W  = 4;
  localparam int MB = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     req_valid;
  logic [4*W-1:0] req_data;
  logic [3:0]     req_last;
  logic [3:0]     req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [1:0]     out_src;
  logic           out_ready;

  mux4_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  logic [4:0] rq [4][$];
  logic [6:0] sb [$];
  logic [3:0] drop;

  int n_chk  = 0;
  int n_pass = 0;

  logic         s_valid;
  logic [3:0]   s_ready;
  logic [3:0]   s_inv;
  logic         s_last;
  logic [1:0]   s_src;
  logic [W-1:0] s_data;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  task automatic drive();
    logic [4:0] h;
    for (int i = 0; i < 4; i++) begin
      h = (rq[i].size() != 0) ? rq[i][0] : 5'd0;
      req_valid[i]       = (rq[i].size() != 0) && !drop[i];
      req_data[i*W +: W] = h[3:0];
      req_last[i]        = h[4];
    end
  endtask

  task automatic load(input int i, input logic [3:0] d, input logic l);
    rq[i].push_back({l, d});
    drive();
  endtask

  task automatic exp_beat(input int src, input logic [3:0] d,
                          input logic l);
    sb.push_back({src[1:0], l, d});
  endtask

  task automatic step();
    logic       fire;
    logic [3:0] taken;
    logic [6:0] e;
    @(negedge clk);
    s_valid = out_valid;
    s_ready = req_ready;
    s_inv   = req_valid;
    s_last  = out_last;
    s_src   = out_src;
    s_data  = out_data;
    chk("rdy_onehot", 32'(s_ready & ~(4'b0001 << s_src)), 32'd0);
    fire = s_valid && out_ready;
    if (fire) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("beat", 32'({s_src, s_last, s_data}), 32'(e));
      end
    end
    taken = s_ready & s_inv;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (taken[i] && rq[i].size() != 0) void'(rq[i].pop_front());
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drop      = '0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    drive();

    // reset with all requesters valid
    load(0, 4'h1, 1'b1);
    load(0, 4'h5, 1'b1);
    load(1, 4'h2, 1'b1);
    load(2, 4'h3, 1'b1);
    load(3, 4'h4, 1'b1);
    repeat (2) step();
    chk("rst_valid", 32'(s_valid), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_src",   32'(s_src),   32'd0);
    chk("rst_last",  32'(s_last),  32'd0);

    // round robin 0,1,2,3,0
    exp_beat(0, 4'h1, 1'b1);
    exp_beat(1, 4'h2, 1'b1);
    exp_beat(2, 4'h3, 1'b1);
    exp_beat(3, 4'h4, 1'b1);
    exp_beat(0, 4'h5, 1'b1);
    rst_n = 1'b1;
    step();
    chk("arb_bubble", 32'(s_valid), 32'd0);
    step();
    chk("first_valid", 32'(s_valid), 32'd1);
    chk("first_src",   32'(s_src),   32'd0);
    drain(40);

    // packet hold: move ptr to 2, then 2 vs 1
    load(1, 4'h1, 1'b1);
    exp_beat(1, 4'h1, 1'b1);
    drain(10);
    load(2, 4'hA, 1'b0);
    load(2, 4'hB, 1'b0);
    load(2, 4'hC, 1'b1);
    load(1, 4'h5, 1'b1);
    exp_beat(2, 4'hA, 1'b0);
    exp_beat(2, 4'hB, 1'b0);
    exp_beat(2, 4'hC, 1'b1);
    exp_beat(1, 4'h5, 1'b1);
    drain(20);

    // backpressure then valid drop
    load(0, 4'h3, 1'b0);
    load(0, 4'h4, 1'b0);
    load(0, 4'h5, 1'b1);
    exp_beat(0, 4'h3, 1'b0);
    exp_beat(0, 4'h4, 1'b0);
    exp_beat(0, 4'h5, 1'b1);
    step();
    step();
    out_ready = 1'b0;
    step();
    chk("bp_valid", 32'(s_valid), 32'd1);
    chk("bp_data",  32'(s_data),  32'h4);
    chk("bp_src",   32'(s_src),   32'd0);
    chk("bp_last",  32'(s_last),  32'd0);
    step();
    chk("bp_hold",  32'(s_data),  32'h4);
    out_ready = 1'b1;
    drop[0]   = 1'b1;
    drive();
    step();
    chk("drop_valid", 32'(s_valid), 32'd0);
    chk("drop_src",   32'(s_src),   32'd0);
    drop[0] = 1'b0;
    drive();
    drain(10);

    // forced release after MAX_BEATS beats from requester 3
    for (int k = 0; k < 10; k++) begin
      load(3, 4'(k), k == 9);
      exp_beat(3, 4'(k), (k == MB - 1) || (k == 9));
    end
    drain(40);
    // ptr wrapped to 0: requester 0 beats 3
    load(3, 4'hE, 1'b1);
    load(0, 4'hD, 1'b1);
    exp_beat(0, 4'hD, 1'b1);
    exp_beat(3, 4'hE, 1'b1);
    drain(20);

    // async reset mid-packet with ptr at 2
    load(1, 4'h1, 1'b1);
    exp_beat(1, 4'h1, 1'b1);
    drain(10);
    load(2, 4'h7, 1'b0);
    load(2, 4'h8, 1'b0);
    load(2, 4'h9, 1'b1);
    exp_beat(2, 4'h7, 1'b0);
    drain(10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_src",   32'(out_src),   32'd0);
    chk("arst_last",  32'(out_last),  32'd0);
    load(1, 4'h6, 1'b1);
    exp_beat(1, 4'h6, 1'b1);
    exp_beat(2, 4'h8, 1'b0);
    exp_beat(2, 4'h9, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4-to-1 data mux among four requesters, each streaming packets over a valid/ready handshake with a per-beat last flag. It sits in front of a single downstream consumer. It grants one requester at a time and holds the grant for a whole packet. It steers the granted requester's data through the mux and returns ready only to that requester. A beat counter forces release after MAX_BEATS beats, so a missing last cannot lock the resource.

## Interface
- WIDTH, 4: data width per requester.
- MAX_BEATS, 8: maximum beats per grant, ≥1. Counter width is $clog2(MAX_BEATS+1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  4  per-requester valid; bit i belongs to requester i.
- req_data  in  4*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_last  in  4  per-requester end-of-packet flag, sampled only on a handshake.
- req_ready  out  4  per-requester ready; at most one bit set.
- out_valid  out  1  downstream valid.
- out_data  out  WIDTH  muxed data of the granted requester.
- out_last  out  1  end of grant. Set when req_last[grant] is set or the beat count reaches MAX_BEATS.
- out_src  out  2  index of the granted requester.
- out_ready  in  1  downstream ready.

## Operation
- Two states: IDLE and BUSY. Registers:
  - grant[1:0]
  - ptr[1:0], the round-robin start point
  - beats, the count of beats completed in the current grant
- IDLE:
  - If any req_valid bit is set, grant is set to the first set bit, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Then beats is cleared and the state moves to BUSY.
  - If no req_valid bit is set, the state stays IDLE.
- BUSY outputs, all combinational from grant:
  - out_valid = req_valid[grant].
  - out_data = req_data slice of grant.
  - out_src = grant.
  - req_ready[grant] = out_ready. All other req_ready bits are 0.
  - out_last = req_last[grant] OR (beats == MAX_BEATS-1).
- Handshake (fire) = out_valid AND out_ready.
- Fire with out_last=1: the state moves to IDLE, ptr ← grant+1 (mod 4), beats ← 0.
- Fire with out_last=0: beats increments.
- No fire: all state is held. If the granted requester drops valid mid-packet, the grant is kept and out_valid is 0. There is no idle timeout.
- In IDLE, out_valid=0, req_ready=0, out_last=0, and out_src=grant, which holds its last value.
- Requests from non-granted requesters never affect outputs during BUSY.
- Data is not registered. Downstream must tolerate a combinational path from req_data to out_data.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, grant=0, ptr=0, beats=0. This forces out_valid=0, req_ready=4'b0000, out_last=0, out_src=0 immediately.
- Reset asserted mid-packet aborts the grant with no further handshake.
- Release is synchronous. The first grant decision happens on the first rising edge after rst_n is high.
- Arbitration latency: a request seen in IDLE at edge k gives out_valid at cycle k+1, at the earliest.
- Each packet costs one IDLE bubble cycle after its last beat.
- Back-to-back throughput in BUSY: one beat per cycle while req_valid and out_ready are both high.
- Pointer wrap: grant=3 on release gives ptr=0.
- Simultaneous requests in IDLE: the pointer order decides.
- A requester that keeps valid high is re-granted only after the other active requesters have each had one grant.
- Forced release at MAX_BEATS: out_last=1 on that beat even if req_last=0. The remaining beats of the packet re-arbitrate as a new grant.
- With MAX_BEATS=1, every beat has out_last=1.

## Test plan
- Reset: hold rst_n=0 with all req_valid=4'b1111 -> out_valid=0, req_ready=0, out_src=0. After release, first grant goes to requester 0 and out_valid=1 one cycle later.
- Round-robin fairness: all four requesters send continuous 1-beat packets (req_last=1) with out_ready=1 -> out_src sequence 0,1,2,3,0. There is one bubble between grants and no starvation.
- Packet hold: requester 2 sends 3 beats (data 0xA, 0xB, 0xC, last on 0xC) while requester 1 is also valid -> out_data reads A,B,C with out_src=2, req_ready[1]=0 throughout, then requester 1 is granted.
- Backpressure and valid drop: out_ready low for 2 cycles mid-packet, then the granted requester drops valid for 1 cycle -> data is held stable, beats do not advance, grant is unchanged, and the packet completes afterwards.
- Forced release: MAX_BEATS=8, requester 3 streams 10 beats with last=0 -> out_last=1 on beat 8 and the state moves to IDLE. With no other requester valid, requester 3 is re-granted and ptr wraps to 0.
- Async reset mid-packet: pull rst_n low between edges during BUSY -> outputs clear immediately, and after release arbitration restarts from ptr=0.
